pwm_from_count: RTL and testbench
=================================

Name: pwm_from_count

Overview:
- Downstream consumer of the 16-bit free-running recycle counter.
- Takes the counter value Q and the recycle flag REL, and owns the counter's active-low count enable n_CEN.
- Produces a PWM waveform whose duty is a double-buffered register, updated only at period boundaries through a valid/ready handshake.
- Sits between the counter and the output pin driver.

Parameters:
- MAXC, 16'h000F, terminal count of the upstream counter; the period is MAXC+1 cycles.
- W, 16, width of the counter value and duty words.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- n_RESET  in  1  asynchronous reset, active low.
- CNT  in  W  counter value (upstream Q). The upstream n_OE is held low, so CNT is always driven.
- REL  in  1  upstream recycle flag; high whenever the counter equals 0.
- n_CEN_OUT  out  1  drives the upstream n_CEN (active-low count enable).
- START  in  1  request to start PWM; sampled in IDLE only.
- STOP  in  1  request for a graceful stop at the end of the current period.
- DUTY_IN  in  W  new duty value (high-cycles per period).
- DUTY_VLD  in  1  DUTY_IN is valid.
- DUTY_RDY  out  1  shadow register empty; a transfer occurs when DUTY_VLD and DUTY_RDY are both high.
- PWM  out  1  registered PWM output.
- BUSY  out  1  high when state is not IDLE.
- PERIOD_CNT  out  8  periods completed since the last START; wraps 255 to 0.

Behaviour:
- Reset (async, n_RESET=0):
  - state=IDLE, n_CEN_OUT=1, PWM=0, BUSY=0, PERIOD_CNT=0.
  - active_duty=0, shadow=0, pending=0, DUTY_RDY=1.
- A boundary is any rising edge where REL=1 and state is RUN or DRAIN.
- FSM states are IDLE, ARM, RUN, DRAIN.
- IDLE:
  - n_CEN_OUT=1, PWM=0.
  - An accepted duty writes active_duty directly; pending stays 0.
  - START=1 -> ARM, n_CEN_OUT<=0, PERIOD_CNT<=0.
- ARM:
  - PWM=0; waits for REL=1 (the counter may have been paused at a nonzero value).
  - On REL=1 -> RUN; PWM<=(CNT<active_duty) at that edge.
  - STOP=1 -> IDLE, n_CEN_OUT<=1. STOP has priority over REL.
- RUN:
  - Every edge: PWM<=(CNT<active_duty), giving 1 cycle of latency from CNT.
  - STOP=1 -> DRAIN.
- DRAIN:
  - Same PWM behaviour as RUN.
  - On the edge where CNT==MAXC: n_CEN_OUT<=1, state<=IDLE, PWM<=0. The counter wraps to 0 on that same edge and then holds at 0 with REL=1.
- Boundary actions:
  - If pending=1: active_duty<=shadow, pending<=0. The new duty applies starting at this edge's CNT=0 comparison.
  - PERIOD_CNT<=PERIOD_CNT+1, except on the first REL seen in ARM.
- Duty handshake:
  - DUTY_RDY = !pending.
  - Accept outside IDLE: shadow<=DUTY_IN, pending<=1.
  - Accept on a boundary edge (pending was 0): the value goes to shadow and takes effect at the next boundary, one period later.
  - DUTY_VLD while DUTY_RDY=0 is ignored; the source must hold DUTY_VLD.
- Arithmetic:
  - Unsigned compare.
  - duty=0 gives PWM constantly 0.
  - duty>MAXC gives PWM constantly 1 while running.
- Simultaneous events:
  - START outside IDLE is ignored.
  - START and STOP together in IDLE: START wins (STOP is meaningless in IDLE).
- Reset mid-operation: all state is cleared immediately and asynchronously, including a pending shadow.

Optional Feature:
- Macro: PWM_IRQ_EN.
- Defined:
  - Adds output IRQ (1 bit, reset 0).
  - IRQ is a registered 1-cycle pulse on every boundary, and on the DRAIN->IDLE transition edge.
- Undefined: no IRQ port and no associated logic; all other behaviour is identical.

Test Plan:
- Reset, then START with duty=5 loaded in IDLE, MAXC=15 -> n_CEN_OUT falls 1 cycle after START; PWM high 5 cycles, low 11 cycles per 16-cycle period; PERIOD_CNT increments every 16 cycles.
- RUN with duty=5; handshake duty=12 mid-period -> DUTY_RDY low until the next REL edge; following period has 12 high cycles; DUTY_RDY returns to 1.
- Duty accepted on the exact boundary edge -> old duty is used for one more period; the new value applies one period later.
- STOP asserted at CNT=7 -> PWM continues to CNT=15; n_CEN_OUT=1, BUSY=0 after that edge; counter holds at 0 with REL=1; PWM=0.
- Duty=0 and duty=16'hFFFF -> PWM constantly 0 and constantly 1 respectively across 3 periods.
- n_RESET pulsed low at CNT=9 in RUN with pending=1 -> PWM=0, n_CEN_OUT=1, DUTY_RDY=1, PERIOD_CNT=0 without waiting for a CLK edge; with PWM_IRQ_EN, IRQ=0.

Source files
------------

// File: rtl/pwm_from_count_if.sv
// Duty-word valid/ready channel into the PWM block.
// Master drives the word and valid; slave answers with ready.
interface pwm_from_count_if #(
  parameter int W = 16
);
  logic [W-1:0] DUTY_IN;
  logic         DUTY_VLD;
  logic         DUTY_RDY;

  modport master (
    output DUTY_IN,
    output DUTY_VLD,
    input  DUTY_RDY
  );

  modport slave (
    input  DUTY_IN,
    input  DUTY_VLD,
    output DUTY_RDY
  );
endinterface

// File: rtl/pwm_from_count.sv
// PWM generator driven by an upstream recycle counter, double-buffered duty.
// Optional IRQ output is enabled by defining PWM_IRQ_EN.
module pwm_from_count #(
  parameter logic [15:0] MAXC = 16'h000F,
  parameter int          W    = 16
) (
  input  logic           CLK,
  input  logic           n_RESET,
  input  logic [W-1:0]   CNT,
  input  logic           REL,
  output logic           n_CEN_OUT,
  input  logic           START,
  input  logic           STOP,
  pwm_from_count_if.slave duty,
  output logic           PWM,
`ifdef PWM_IRQ_EN
  output logic           IRQ,
`endif
  output logic           BUSY,
  output logic [7:0]     PERIOD_CNT
);

  localparam logic [W-1:0] MAXW = W'(MAXC);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN
  } st_e;

  st_e          st_q, st_d;
  logic         pwm_q, pwm_d;
  logic         ncen_q, ncen_d;
  logic [7:0]   pcnt_q, pcnt_d;
  logic [W-1:0] act_q, act_d;
  logic [W-1:0] shd_q, shd_d;
  logic         pend_q, pend_d;

  logic         bnd;
  logic         acc;
  logic         last;
  logic         cmp;
  logic [W-1:0] duty_eff;

  assign bnd  = REL && (st_q == RUN || st_q == DRAIN);
  assign acc  = duty.DUTY_VLD && !pend_q;
  assign last = (st_q == DRAIN) && (CNT == MAXW);

  // A duty promoted on this boundary already governs this edge's compare
  assign duty_eff = (bnd && pend_q) ? shd_q : act_q;
  assign cmp      = CNT < duty_eff;

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) st_q <= IDLE;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (START) st_d = ARM;
      ARM: begin
        if (STOP)     st_d = IDLE;
        else if (REL) st_d = RUN;
      end
      RUN:     if (STOP) st_d = DRAIN;
      DRAIN:   if (last) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    pwm_d  = 1'b0;
    ncen_d = ncen_q;
    pcnt_d = pcnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;

    unique case (st_q)
      IDLE: begin
        if (START) begin
          ncen_d = 1'b0;
          pcnt_d = 8'd0;
        end
      end
      ARM: begin
        if (STOP)     ncen_d = 1'b1;
        else if (REL) pwm_d  = cmp;
      end
      RUN:   pwm_d = cmp;
      DRAIN: begin
        if (last) ncen_d = 1'b1;
        else      pwm_d  = cmp;
      end
      default: pwm_d = 1'b0;
    endcase

    if (bnd) pcnt_d = pcnt_q + 8'd1;

    if (bnd && pend_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end else if (acc) begin
      if (st_q == IDLE) begin
        act_d = duty.DUTY_IN;
      end else begin
        shd_d  = duty.DUTY_IN;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      pwm_q  <= 1'b0;
      ncen_q <= 1'b1;
      pcnt_q <= 8'd0;
      act_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      pwm_q  <= pwm_d;
      ncen_q <= ncen_d;
      pcnt_q <= pcnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
    end
  end

`ifdef PWM_IRQ_EN
  logic irq_q;

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) irq_q <= 1'b0;
    else          irq_q <= bnd || last;
  end

  assign IRQ = irq_q;
`endif

  assign PWM           = pwm_q;
  assign n_CEN_OUT     = ncen_q;
  assign PERIOD_CNT    = pcnt_q;
  assign BUSY          = (st_q != IDLE);
  assign duty.DUTY_RDY = !pend_q;

endmodule

// File: tb/tb_pwm_from_count.sv
// Bench for pwm_from_count: upstream counter model, table vectors,
// directed period sequences and a randomized run against a reference model.
module tb_pwm_from_count;

  localparam int MAXC = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cnt;
  logic        rel;
  logic        ncen;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pwm;
  logic        busy;
  logic [7:0]  pcnt;
`ifdef PWM_IRQ_EN
  logic        irq;
`endif

  int nvec = 0;
  int nbad = 0;

  pwm_from_count_if #(.W(16)) dif ();

  pwm_from_count #(
    .MAXC(16'h000F),
    .W   (16)
  ) dut (
    .CLK       (clk),
    .n_RESET   (rst_n),
    .CNT       (cnt),
    .REL       (rel),
    .n_CEN_OUT (ncen),
    .START     (start),
    .STOP      (stop),
    .duty      (dif.slave),
    .PWM       (pwm),
`ifdef PWM_IRQ_EN
    .IRQ       (irq),
`endif
    .BUSY      (busy),
    .PERIOD_CNT(pcnt)
  );

  always #5 clk = ~clk;

  // Upstream recycle counter: counts 0..MAXC while n_CEN is low
  assign rel = (cnt == 16'd0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= 16'd0;
    else if (!ncen) cnt <= (int'(cnt) == MAXC) ? 16'd0 : cnt + 16'd1;
  end

  // Reference model: spec-level states, a duty queue of depth one
  typedef enum {M_IDLE, M_ARM, M_RUN, M_DRAIN} mst_e;
  mst_e        m_st;
  int          m_duty;
  logic [15:0] m_q[$];
  int          m_pc;
  bit          m_pwm;
  bit          m_ncen;
  bit          m_irq;

  typedef struct {
    bit          st;
    bit          sp;
    bit          v;
    logic [15:0] d;
    bit          e_pwm;
    bit          e_ncen;
    bit          e_busy;
    bit          e_rdy;
    int          e_pc;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = M_IDLE;
    m_duty = 0;
    m_q.delete();
    m_pc   = 0;
    m_pwm  = 1'b0;
    m_ncen = 1'b1;
    m_irq  = 1'b0;
  endtask

  task automatic model_step(input bit st, sp, v, input logic [15:0] d);
    bit r, bnd, acc;
    int c;
    c   = int'(cnt);
    r   = (c == 0);
    bnd = r && (m_st == M_RUN || m_st == M_DRAIN);
    acc = v && (m_q.size() == 0);
    m_irq = bnd || (m_st == M_DRAIN && c == MAXC);
    if (bnd) begin
      m_pc = (m_pc + 1) % 256;
      if (m_q.size() != 0) m_duty = int'(m_q.pop_front());
    end
    if (acc) begin
      if (m_st == M_IDLE) m_duty = int'(d);
      else                m_q.push_back(d);
    end
    case (m_st)
      M_IDLE: begin
        m_pwm = 1'b0;
        if (st) begin
          m_st   = M_ARM;
          m_ncen = 1'b0;
          m_pc   = 0;
        end
      end
      M_ARM: begin
        m_pwm = 1'b0;
        if (sp) begin
          m_st   = M_IDLE;
          m_ncen = 1'b1;
        end else if (r) begin
          m_st  = M_RUN;
          m_pwm = (c < m_duty);
        end
      end
      M_RUN: begin
        m_pwm = (c < m_duty);
        if (sp) m_st = M_DRAIN;
      end
      default: begin
        if (c == MAXC) begin
          m_st   = M_IDLE;
          m_ncen = 1'b1;
          m_pwm  = 1'b0;
        end else begin
          m_pwm = (c < m_duty);
        end
      end
    endcase
  endtask

  task automatic tick(input bit st, sp, v, input logic [15:0] d);
    start        = st;
    stop         = sp;
    dif.DUTY_VLD = v;
    dif.DUTY_IN  = d;
    model_step(st, sp, v, d);
    @(posedge clk);
    #1;
    chk("pwm", int'(pwm), int'(m_pwm));
    chk("n_cen", int'(ncen), int'(m_ncen));
    chk("busy", int'(busy), int'(m_st != M_IDLE));
    chk("rdy", int'(dif.DUTY_RDY), int'(m_q.size() == 0));
    chk("period_cnt", int'(pcnt), m_pc);
`ifdef PWM_IRQ_EN
    chk("irq", int'(irq), int'(m_irq));
`endif
    start        = 1'b0;
    stop         = 1'b0;
    dif.DUTY_VLD = 1'b0;
  endtask

  task automatic sync_to(input int c);
    int n;
    n = 0;
    while (int'(cnt) != c && n < 64) begin
      tick(0, 0, 0, 16'd0);
      n++;
    end
    chk("sync_cnt", int'(cnt), c);
  endtask

  task automatic count_high(input int exp, input bit v0, input logic [15:0] d0);
    int h;
    h = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) tick(0, 0, v0, d0);
      else        tick(0, 0, 0, 16'd0);
      h += int'(pwm);
    end
    chk("period_high", h, exp);
  endtask

  task automatic drain_stop();
    tick(0, 1, 0, 16'd0);
    sync_to(MAXC);
    tick(0, 0, 0, 16'd0);
    chk("drain_idle", int'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.DUTY_IN  = 16'd0;
    dif.DUTY_VLD = 1'b0;
    model_reset();

    tbl[0] = '{0, 0, 1, 16'd5, 0, 1, 0, 1, 0};
    tbl[1] = '{1, 0, 0, 16'd0, 0, 0, 1, 1, 0};
    tbl[2] = '{0, 0, 0, 16'd0, 1, 0, 1, 1, 0};
    tbl[3] = '{0, 0, 0, 16'd0, 1, 0, 1, 1, 0};
    tbl[4] = '{0, 0, 0, 16'd0, 1, 0, 1, 1, 0};
    tbl[5] = '{0, 0, 0, 16'd0, 1, 0, 1, 1, 0};
    tbl[6] = '{0, 0, 0, 16'd0, 1, 0, 1, 1, 0};
    tbl[7] = '{0, 0, 0, 16'd0, 0, 0, 1, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_ncen", int'(ncen), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pcnt", int'(pcnt), 0);
    chk("rst_rdy", int'(dif.DUTY_RDY), 1);
`ifdef PWM_IRQ_EN
    chk("rst_irq", int'(irq), 0);
`endif
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      tick(tbl[i].st, tbl[i].sp, tbl[i].v, tbl[i].d);
      chk("tbl_pwm", int'(pwm), int'(tbl[i].e_pwm));
      chk("tbl_ncen", int'(ncen), int'(tbl[i].e_ncen));
      chk("tbl_busy", int'(busy), int'(tbl[i].e_busy));
      chk("tbl_rdy", int'(dif.DUTY_RDY), int'(tbl[i].e_rdy));
      chk("tbl_pcnt", int'(pcnt), tbl[i].e_pc);
    end

    sync_to(0);
    count_high(5, 0, 16'd0);
    count_high(5, 0, 16'd0);
    chk("pcnt_two", int'(pcnt), 2);

    // Mid-period duty update waits for the next boundary
    sync_to(7);
    tick(0, 0, 1, 16'd12);
    chk("rdy_low", int'(dif.DUTY_RDY), 0);
    sync_to(0);
    chk("rdy_low_b", int'(dif.DUTY_RDY), 0);
    count_high(12, 0, 16'd0);
    chk("rdy_back", int'(dif.DUTY_RDY), 1);

    // Accepted on the boundary edge itself: one more period at old duty
    count_high(12, 1, 16'd16);
    count_high(16, 0, 16'd0);

    // Graceful stop requested at CNT=7
    sync_to(7);
    tick(0, 1, 0, 16'd0);
    chk("drain_busy", int'(busy), 1);
    sync_to(MAXC);
    chk("drain_pwm", int'(pwm), 1);
    tick(0, 0, 0, 16'd0);
    chk("stop_ncen", int'(ncen), 1);
    chk("stop_busy", int'(busy), 0);
    chk("stop_pwm", int'(pwm), 0);
    repeat (3) tick(0, 0, 0, 16'd0);
    chk("hold_cnt", int'(cnt), 0);
    chk("hold_rel", int'(rel), 1);
    chk("hold_pwm", int'(pwm), 0);

    // Duty extremes
    tick(0, 0, 1, 16'd0);
    tick(1, 0, 0, 16'd0);
    sync_to(0);
    repeat (3) count_high(0, 0, 16'd0);
    drain_stop();
    tick(0, 0, 1, 16'hFFFF);
    tick(1, 0, 0, 16'd0);
    sync_to(0);
    repeat (3) count_high(16, 0, 16'd0);
    drain_stop();

    // Async reset in RUN with a pending shadow
    tick(0, 0, 1, 16'd15);
    tick(1, 0, 0, 16'd0);
    tick(0, 0, 0, 16'd0);
    sync_to(0);
    tick(0, 0, 0, 16'd0);
    sync_to(3);
    tick(0, 0, 1, 16'd9);
    sync_to(9);
    chk("pre_rst_pwm", int'(pwm), 1);
    chk("pre_rst_rdy", int'(dif.DUTY_RDY), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'(pwm), 0);
    chk("arst_ncen", int'(ncen), 1);
    chk("arst_rdy", int'(dif.DUTY_RDY), 1);
    chk("arst_pcnt", int'(pcnt), 0);
    chk("arst_busy", int'(busy), 0);
`ifdef PWM_IRQ_EN
    chk("arst_irq", int'(irq), 0);
`endif
    model_reset();
    #2;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int          r;
      logic [15:0] d;
      r = int'($urandom_range(0, 9));
      if (r == 0)      d = 16'd0;
      else if (r == 1) d = 16'hFFFF;
      else if (r == 2) d = 16'd16;
      else             d = 16'($urandom_range(0, 17));
      tick($urandom_range(0, 15) == 0,
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 3) == 0,
           d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
